imem_line_buffer: RTL and testbench
===================================

IMEM_LINE_BUFFER -- requirements
Module: imem_line_buffer

Interface
REQ-001 Parameter LINE_WORDS, default 4, gives the words per line; power of two, 2..16.
REQ-002 Parameter NOP_WORD, default 32'h00000013, is the instruction returned on a miss.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high.
REQ-005 Port iaddr, input, 32, fetch address from the IF stage.
REQ-006 Port idata, output, 32, instruction word back to the IF stage.
REQ-007 Port ihit, output, 1, high when idata is valid for the current iaddr.
REQ-008 Port fence_i, input, 1, single-cycle request to invalidate the buffered line.
REQ-009 Port mem_req, output, 1, backing-memory read request.
REQ-010 Port mem_addr, output, 32, word-aligned backing-memory read address.
REQ-011 Port mem_rdata, input, 32, backing-memory read data.
REQ-012 Port mem_rvalid, input, 1, mem_rdata valid; accepts the current request.

Function
REQ-013 Storage: one line of LINE_WORDS x 32-bit words, a tag equal to iaddr[31:log2(LINE_WORDS)+2], and a line_valid bit.
REQ-014 Hit condition: state IDLE, line_valid=1 and tag match. Hit is purely combinational from iaddr.
REQ-015 On a hit, ihit=1 and idata is the buffered word selected by iaddr[log2(LINE_WORDS)+1:2], in the same cycle (zero latency).
REQ-016 On a non-hit, ihit=0 and idata=NOP_WORD. The IF stage uses ~ihit as a stall source.
REQ-017 iaddr[1:0] is ignored; no alignment fault is raised.
REQ-018 FSM states: IDLE and FILL.
REQ-019 IDLE -> FILL on a miss. The tag is latched from iaddr, beat=0, line_valid is cleared, and the fill base is iaddr with bits [log2(LINE_WORDS)+1:0] zeroed.
REQ-020 In FILL, mem_req=1 and mem_addr = base + 4*beat, both held stable until mem_rvalid.
REQ-021 On mem_rvalid in FILL, mem_rdata is written to word[beat] and beat increments.
REQ-022 On mem_rvalid with beat=LINE_WORDS-1: line_valid is set unless the invalidate-pending flag (REQ-025) is set; FSM returns to IDLE; mem_req drops next cycle.
REQ-023 The fill is critical-word-agnostic: it always starts at beat 0 and is never aborted by an iaddr change. After the fill returns to IDLE, hit is re-evaluated against the then-current iaddr.
REQ-024 mem_rvalid in IDLE is ignored.
REQ-025 fence_i in IDLE clears line_valid next cycle. fence_i in FILL sets an invalidate-pending flag; the completing fill then leaves line_valid=0 and clears the flag.
REQ-026 A fence_i in the same cycle as a hit still returns that cycle's hit data.
REQ-027 Minimum miss penalty is LINE_WORDS+1 cycles with mem_rvalid returned the cycle after each request.

Reset
REQ-028 On reset: state=IDLE, beat=0, line_valid=0, invalidate-pending=0, mem_req=0, mem_addr=0, ihit=0, idata=NOP_WORD.
REQ-029 Reset mid-FILL abandons the fill. mem_rvalid arriving after reset is ignored (REQ-024).
REQ-030 Line data words are not reset.

Structure
REQ-031 A shared package holds the NOP_WORD constant (RISC-V ADDI x0,x0,0) and the FSM state enumeration.
REQ-032 No sub-module is required. The line storage may be a flat register array inside the block.

Verification
REQ-033 Cold fetch: after reset, iaddr=0x100 with memory returning rvalid one cycle after each request -> ihit=0 and idata=0x00000013 for 5 cycles; mem_addr sequence is 0x100, 0x104, 0x108, 0x10C; then ihit=1 with idata=mem[0x100].
REQ-034 Sequential hits: after filling line 0x100, iaddr=0x104, 0x108, 0x10C on consecutive cycles -> ihit=1 every cycle, data matches memory, mem_req=0.
REQ-035 Redirect during fill: iaddr moves 0x100 -> 0x200 at beat 1 -> fill of 0x100 completes, then one IDLE cycle, then a new fill starting at mem_addr=0x200.
REQ-036 fence_i: pulse during beat 2 of a fill -> line_valid=0 after the fill and iaddr=0x100 misses again. Pulse in IDLE with a valid line -> a hit that cycle, then a miss on the next cycle.
REQ-037 Memory backpressure: rvalid withheld 3 cycles per beat -> mem_addr and mem_req stay stable while waiting; the line fills correctly in 16 cycles.
REQ-038 Reset at beat 2 of a fill -> mem_req=0 next cycle, a stray rvalid is ignored, and iaddr=0x100 starts a fresh fill at beat 0.

Source files
------------

// File: rtl/imem_line_buffer_pkg.sv
// Shared constants and types for the single-line instruction buffer.
package imem_line_buffer_pkg;

  // RISC-V ADDI x0,x0,0
  localparam logic [31:0] NopWord = 32'h0000_0013;

  typedef enum logic [0:0] {
    StIdle,
    StFill
  } state_e;

endpackage

// File: rtl/imem_line_buffer.sv
// One-line instruction buffer: zero-latency hits, in-order line fill on a miss.
module imem_line_buffer
  import imem_line_buffer_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] NOP_WORD   = NopWord
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  output logic        ihit,
  input  logic        fence_i,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam int unsigned OffW   = $clog2(LINE_WORDS);
  localparam int unsigned TagLsb = OffW + 2;
  localparam logic [OffW-1:0] LastBeat = OffW'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [OffW-1:0]   beat_q, beat_d;
  logic              line_valid_q, line_valid_d;
  logic              inv_pend_q, inv_pend_d;
  logic [31:TagLsb]  tag_q, tag_d;
  logic [31:0]       words_q [LINE_WORDS];
  logic              word_we;
  logic              hit;

  assign hit   = (state_q == StIdle) && line_valid_q && (iaddr[31:TagLsb] == tag_q);
  assign ihit  = hit;
  assign idata = hit ? words_q[iaddr[TagLsb-1:2]] : NOP_WORD;

  assign mem_req  = (state_q == StFill);
  // The fill base is the tag with the line offset zeroed, so no separate base register.
  assign mem_addr = mem_req ? {tag_q, beat_q, 2'b00} : 32'h0;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_valid_d = line_valid_q;
    inv_pend_d   = inv_pend_q;
    tag_d        = tag_q;
    word_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fence_i) line_valid_d = 1'b0;
        if (!hit) begin
          state_d      = StFill;
          tag_d        = iaddr[31:TagLsb];
          beat_d       = '0;
          line_valid_d = 1'b0;
          inv_pend_d   = 1'b0;
        end
      end
      StFill: begin
        if (fence_i) inv_pend_d = 1'b1;
        if (mem_rvalid) begin
          word_we = 1'b1;
          beat_d  = beat_q + OffW'(1);
          if (beat_q == LastBeat) begin
            state_d      = StIdle;
            // A fence seen anywhere during the fill, including this last beat, wins.
            line_valid_d = !(inv_pend_q || fence_i);
            inv_pend_d   = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      line_valid_q <= 1'b0;
      inv_pend_q   <= 1'b0;
      tag_q        <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_valid_q <= line_valid_d;
      inv_pend_q   <= inv_pend_d;
      tag_q        <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we && !reset) words_q[beat_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_imem_line_buffer.sv
// Directed, table-driven bench for imem_line_buffer with a latency-programmable memory model.
module tb_imem_line_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        ihit;
  logic        fence_i;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wait_cnt = 0;
  logic force_rv = 1'b0;

  always #5 clk = ~clk;

  imem_line_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .iaddr     (iaddr),
    .idata     (idata),
    .ihit      (ihit),
    .fence_i   (fence_i),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Memory answers once the request has been held for `lat` extra cycles.
  always_comb begin
    mem_rvalid = force_rv | (mem_req && (wait_cnt >= lat));
    mem_rdata  = force_rv ? 32'hDEAD_BEEF : mem_word(mem_addr);
  end

  always_ff @(posedge clk) begin
    if (reset || !mem_req || mem_rvalid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [31:0] a;
    logic        f;
    logic        eh;
    logic [31:0] ed;
    logic        er;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] a, input logic f, input logic eh,
                              input logic [31:0] ed, input logic er, input logic [31:0] ea);
    vec_t v;
    v.a = a; v.f = f; v.eh = eh; v.ed = ed; v.er = er; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one cycle, compare at the falling edge, advance past the rising edge.
  task automatic cyc(input string name, input logic [31:0] a, input logic f, input logic eh,
                     input logic [31:0] ed, input logic er, input logic [31:0] ea);
    iaddr   = a;
    fence_i = f;
    @(negedge clk);
    chk({name, ".ihit"}, {31'h0, ihit}, {31'h0, eh});
    chk({name, ".idata"}, idata, ed);
    chk({name, ".mem_req"}, {31'h0, mem_req}, {31'h0, er});
    chk({name, ".mem_addr"}, mem_addr, ea);
    @(posedge clk);
    #1;
    fence_i = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    fence_i  = 1'b0;
    force_rv = 1'b0;
    iaddr    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [31:0] Nop = 32'h0000_0013;

  initial begin
    reset = 1'b1; iaddr = '0; fence_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ihit", {31'h0, ihit}, 32'h0);
    chk("reset.idata", idata, Nop);
    chk("reset.mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset.mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold fetch, sequential hits, unaligned fetch, fence in IDLE, line replacement.
    tbl.push_back(mk(32'h100, 0, 0, Nop, 0, 32'h0));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h100));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h104));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h108));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h10C));
    tbl.push_back(mk(32'h100, 0, 1, mem_word(32'h100), 0, 32'h0));
    tbl.push_back(mk(32'h104, 0, 1, mem_word(32'h104), 0, 32'h0));
    tbl.push_back(mk(32'h108, 0, 1, mem_word(32'h108), 0, 32'h0));
    tbl.push_back(mk(32'h10C, 0, 1, mem_word(32'h10C), 0, 32'h0));
    tbl.push_back(mk(32'h107, 0, 1, mem_word(32'h104), 0, 32'h0));
    tbl.push_back(mk(32'h100, 1, 1, mem_word(32'h100), 0, 32'h0));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 0, 32'h0));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h100));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h104));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h108));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 1, 32'h10C));
    tbl.push_back(mk(32'h10C, 0, 1, mem_word(32'h10C), 0, 32'h0));
    tbl.push_back(mk(32'h110, 0, 0, Nop, 0, 32'h0));
    tbl.push_back(mk(32'h110, 0, 0, Nop, 1, 32'h110));
    tbl.push_back(mk(32'h110, 0, 0, Nop, 1, 32'h114));
    tbl.push_back(mk(32'h110, 0, 0, Nop, 1, 32'h118));
    tbl.push_back(mk(32'h110, 0, 0, Nop, 1, 32'h11C));
    tbl.push_back(mk(32'h118, 0, 1, mem_word(32'h118), 0, 32'h0));
    tbl.push_back(mk(32'h100, 0, 0, Nop, 0, 32'h0));

    lat = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("tbl[%0d]", i), tbl[i].a, tbl[i].f, tbl[i].eh, tbl[i].ed, tbl[i].er,
          tbl[i].ea);
    end

    // Redirect at beat 1: old fill completes, one IDLE miss cycle, then new fill.
    do_reset();
    cyc("redir.c0", 32'h100, 0, 0, Nop, 0, 32'h0);
    cyc("redir.c1", 32'h100, 0, 0, Nop, 1, 32'h100);
    cyc("redir.c2", 32'h200, 0, 0, Nop, 1, 32'h104);
    cyc("redir.c3", 32'h200, 0, 0, Nop, 1, 32'h108);
    cyc("redir.c4", 32'h200, 0, 0, Nop, 1, 32'h10C);
    cyc("redir.c5", 32'h200, 0, 0, Nop, 0, 32'h0);
    cyc("redir.c6", 32'h200, 0, 0, Nop, 1, 32'h200);

    // fence_i during beat 2 leaves the line invalid.
    do_reset();
    cyc("fill_fence.c0", 32'h100, 0, 0, Nop, 0, 32'h0);
    cyc("fill_fence.c1", 32'h100, 0, 0, Nop, 1, 32'h100);
    cyc("fill_fence.c2", 32'h100, 0, 0, Nop, 1, 32'h104);
    cyc("fill_fence.c3", 32'h100, 1, 0, Nop, 1, 32'h108);
    cyc("fill_fence.c4", 32'h100, 0, 0, Nop, 1, 32'h10C);
    cyc("fill_fence.c5", 32'h100, 0, 0, Nop, 0, 32'h0);
    cyc("fill_fence.c6", 32'h100, 0, 0, Nop, 1, 32'h100);

    // Backpressure: 3 wait cycles per beat, 16 fill cycles total.
    do_reset();
    lat = 3;
    cyc("bp.c0", 32'h100, 0, 0, Nop, 0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      cyc($sformatf("bp.fill%0d", k), 32'h100, 0, 0, Nop, 1, 32'h100 + 32'(4 * (k / 4)));
    end
    for (int w = 0; w < 4; w++) begin
      cyc($sformatf("bp.hit%0d", w), 32'h100 + 32'(4 * w), 0, 1,
          mem_word(32'h100 + 32'(4 * w)), 0, 32'h0);
    end
    lat = 0;

    // Reset at beat 2, stray rvalid after reset, fresh fill from beat 0.
    do_reset();
    cyc("rst_fill.c0", 32'h100, 0, 0, Nop, 0, 32'h0);
    cyc("rst_fill.c1", 32'h100, 0, 0, Nop, 1, 32'h100);
    cyc("rst_fill.c2", 32'h100, 0, 0, Nop, 1, 32'h104);
    reset = 1'b1;
    cyc("rst_fill.c3", 32'h100, 0, 0, Nop, 1, 32'h108);
    reset    = 1'b0;
    force_rv = 1'b1;
    cyc("rst_fill.c4", 32'h100, 0, 0, Nop, 0, 32'h0);
    force_rv = 1'b0;
    cyc("rst_fill.c5", 32'h100, 0, 0, Nop, 1, 32'h100);
    cyc("rst_fill.c6", 32'h100, 0, 0, Nop, 1, 32'h104);
    cyc("rst_fill.c7", 32'h100, 0, 0, Nop, 1, 32'h108);
    cyc("rst_fill.c8", 32'h100, 0, 0, Nop, 1, 32'h10C);
    cyc("rst_fill.c9", 32'h100, 0, 1, mem_word(32'h100), 0, 32'h0);
    cyc("rst_fill.c10", 32'h108, 0, 1, mem_word(32'h108), 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
